// File: rtl/dual_queue_arbiter.sv
// Two circular FIFOs sharing one single-port synchronous RAM, each queue
// owning one half of the address space, with a round-robin access arbiter.
//
// Ports:
//   CLK, RST          clock, asynchronous active-high reset
//   WR_REQ, RD_REQ    per-queue requests (bit c = queue c), held until granted
//   Din0, Din1        write data for queue 0 / 1, sampled on the grant edge
//   WR_GNT, RD_GNT    registered one-cycle grant pulses
//   full, Empty       per-queue status, decoded from the registered counts
//   Dout, RD_VALID    read data and the one-cycle pulse naming its queue
//   ram_addr, ram_din, ram_read, ram_write   registered RAM commands
//   ram_dout          RAM read data, valid one cycle after ram_read
module dual_queue_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 10,
  parameter int MEM_SIZE   = 256
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [1:0]            WR_REQ,
  input  logic [1:0]            RD_REQ,
  input  logic [DATA_WIDTH-1:0] Din0,
  input  logic [DATA_WIDTH-1:0] Din1,
  output logic [1:0]            WR_GNT,
  output logic [1:0]            RD_GNT,
  output logic [1:0]            full,
  output logic [1:0]            Empty,
  output logic [DATA_WIDTH-1:0] Dout,
  output logic [1:0]            RD_VALID,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_read,
  output logic                  ram_write,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  localparam int HALF = MEM_SIZE / 2;
  localparam int PW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int CW   = $clog2(HALF + 1);

  localparam logic [ADDR_WIDTH-1:0] BASE1 = ADDR_WIDTH'(HALF);
  localparam logic [PW-1:0]         PMAX  = PW'(HALF - 1);
  localparam logic [CW-1:0]         CFULL = CW'(HALF);

  logic [1:0][PW-1:0]     r_head;
  logic [1:0][PW-1:0]     r_tail;
  logic [1:0][CW-1:0]     r_cnt;
  logic [1:0]             r_last;
  logic [1:0]             r_wr_gnt;
  logic [1:0]             r_rd_gnt;
  logic [1:0]             r_rd_valid;
  logic                   r_ram_read;
  logic                   r_ram_write;
  logic [ADDR_WIDTH-1:0]  r_ram_addr;
  logic [DATA_WIDTH-1:0]  r_ram_din;

  logic [3:0]             w_elig;
  logic                   w_found;
  logic [1:0]             w_slot;
  logic [1:0]             w_idx;
  logic                   w_q;
  logic                   w_rd;
  logic [1:0]             w_qsel;
  logic [PW-1:0]          w_ptr;
  logic [PW-1:0]          w_ptr_nxt;
  logic [ADDR_WIDTH-1:0]  w_addr;

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      full[c]  = (r_cnt[c] == CFULL);
      Empty[c] = (r_cnt[c] == '0);
    end
  end

  // Slot order: 0 = WR0, 1 = RD0, 2 = WR1, 3 = RD1
  assign w_elig = {RD_REQ[1] & ~Empty[1],
                   WR_REQ[1] & ~full[1],
                   RD_REQ[0] & ~Empty[0],
                   WR_REQ[0] & ~full[0]};

  // Round-robin: scan upward from last grant + 1; 2-bit add wraps
  always_comb begin
    w_found = 1'b0;
    w_slot  = r_last;
    w_idx   = '0;
    for (int i = 1; i <= 4; i++) begin
      w_idx = r_last + 2'(i);
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_slot  = w_idx;
      end
    end
  end

  assign w_q       = w_slot[1];
  assign w_rd      = w_slot[0];
  assign w_qsel    = w_q ? 2'b10 : 2'b01;
  assign w_ptr     = w_rd ? r_head[w_q] : r_tail[w_q];
  assign w_ptr_nxt = (w_ptr == PMAX) ? '0 : w_ptr + 1'b1;
  assign w_addr    = (w_q ? BASE1 : '0) + ADDR_WIDTH'(w_ptr);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_cnt       <= '0;
      r_last      <= 2'd3;
      r_wr_gnt    <= '0;
      r_rd_gnt    <= '0;
      r_rd_valid  <= '0;
      r_ram_read  <= 1'b0;
      r_ram_write <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_din   <= '0;
    end else begin
      r_wr_gnt    <= '0;
      r_rd_gnt    <= '0;
      r_ram_read  <= 1'b0;
      r_ram_write <= 1'b0;
      // RAM data lands one cycle after the read command
      r_rd_valid  <= r_rd_gnt;
      if (w_found) begin
        r_last     <= w_slot;
        r_ram_addr <= w_addr;
        if (w_rd) begin
          r_ram_read   <= 1'b1;
          r_rd_gnt     <= w_qsel;
          r_head[w_q]  <= w_ptr_nxt;
          r_cnt[w_q]   <= r_cnt[w_q] - CW'(1);
        end else begin
          r_ram_write  <= 1'b1;
          r_ram_din    <= w_q ? Din1 : Din0;
          r_wr_gnt     <= w_qsel;
          r_tail[w_q]  <= w_ptr_nxt;
          r_cnt[w_q]   <= r_cnt[w_q] + CW'(1);
        end
      end
    end
  end

  assign WR_GNT    = r_wr_gnt;
  assign RD_GNT    = r_rd_gnt;
  assign RD_VALID  = r_rd_valid;
  assign ram_read  = r_ram_read;
  assign ram_write = r_ram_write;
  assign ram_addr  = r_ram_addr;
  assign ram_din   = r_ram_din;
  // Gated so Dout reads 0 outside a valid pulse
  assign Dout      = (|r_rd_valid) ? ram_dout : '0;

endmodule
